prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Upstream boot stage for the cpu. Receives a framed byte stream (valid/ready, e.g. from a UART RX).
//  Packs byte pairs into 14-bit instruction words and writes them into program memory (Program_Rom write port).
//  Holds the cpu in reset (cpu_hold) until a complete, checksum-verified program has been written.
// PARAMETERS
//  ADDR_W  11    program memory address width
//  WORD_W  14    instruction width; fixed at 14
//  DEPTH   2048  maximum words accepted; must be <= 2**ADDR_W
// PORTS
//  clk         in   1       clock
//  reset       in   1       reset, synchronous, active-high
//  start       in   1       one-cycle pulse: begin a load
//  rx_data     in   8       incoming byte
//  rx_valid    in   1       rx_data valid
//  rx_ready    out  1       loader can accept a byte
//  mem_we      out  1       program memory write strobe, one cycle per word
//  mem_addr    out  ADDR_W  write address
//  mem_wdata   out  WORD_W  write data
//  cpu_hold    out  1       1 = keep cpu in reset (OR into cpu reset)
//  done        out  1       level: valid program loaded
//  error       out  1       level: load aborted
//  word_count  out  ADDR_W+1  words written in the current load
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, except cpu_hold = 1; state = IDLE.
//  Byte accept: the cycle with rx_valid & rx_ready.
//   - rx_ready = 1 only in LEN_HI, LEN_LO, W_HI, W_LO and CHK; 0 in IDLE, DONE and ERR.
//  Frame: LEN_HI, LEN_LO, N x (HI, LO), CHK.
//   - N = {LEN_HI, LEN_LO}, 16-bit big-endian word count.
//   - word = {HI[5:0], LO}.
//   - CHK makes the 8-bit sum of every frame byte, including CHK, equal to 0 mod 256.
//  FSM states: IDLE, LEN_HI, LEN_LO, W_HI, W_LO, CHK, DONE, ERR.
//   - IDLE:   start -> LEN_HI. Also clears word_count, addr index and checksum accumulator.
//   - LEN_HI: accept -> LEN_LO.
//   - LEN_LO: accept -> ERR if N == 0 or N > DEPTH; otherwise -> W_HI.
//   - W_HI:   accept -> ERR if HI[7:6] != 0; that word is not written. Otherwise -> W_LO.
//   - W_LO:   accept -> W_HI, or -> CHK if this was word N.
//   - CHK:    accept -> DONE if sum == 0; otherwise -> ERR.
//   - DONE:   done = 1, cpu_hold = 0. start -> LEN_HI, with done = 0 and cpu_hold = 1 on the next cycle.
//   - ERR:    error = 1, cpu_hold = 1. start -> LEN_HI and clears error.
//  Write timing (latency 1 cycle):
//   - mem_we is registered and asserts the cycle after a W_LO accept.
//   - In that cycle mem_addr = word index (0-based) and mem_wdata = packed word.
//   - word_count increments in the same cycle.
//   - mem_addr and mem_wdata hold their values when mem_we = 0.
//  Back-to-back bytes: rx_ready stays high during the write cycle, so the next HI byte may be accepted concurrently.
//  start is ignored in LEN_HI..CHK.
//  rx_valid gaps in any state: the state holds and nothing changes.
//  Words written before an ERR are not erased; the cpu stays held.
//  Checksum accumulator is 8-bit, wraps modulo 256, and includes all bytes from LEN_HI through CHK.
//  reset mid-load takes effect in the next cycle:
//   - state -> IDLE, cpu_hold = 1, mem_we = 0, counters cleared.
//   - memory already written is left as is.
// TESTING
//  1. Reset for 2 cycles -> cpu_hold = 1, rx_ready = 0, done = 0, error = 0, mem_we = 0.
//  2. Good 2-word load: start, then bytes 00 02 28 05 07 81 49, no gaps.
//     - Writes: addr 0 = 0x2805, then addr 1 = 0x0781.
//     - End state: done = 1, cpu_hold = 0, word_count = 2.
//  3. Bad checksum: same frame with CHK = 48.
//     - Both words are written.
//     - Then error = 1, done = 0, cpu_hold = 1, rx_ready = 0.
//  4. Bad length:
//     - LEN 00 00 -> ERR after the 2nd byte, no mem_we.
//     - LEN 08 01 (DEPTH = 2048) -> ERR, no mem_we.
//  5. Bad high byte: frame 00 01 C0 ... -> ERR on the C0 accept, no mem_we. Then start plus a valid frame -> done = 1.
//  6. Random rx_valid gaps plus reset after 3 bytes:
//     - On reset: IDLE, rx_ready = 0, cpu_hold = 1.
//     - Then start during the new load is ignored, and a full frame completes correctly.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: unpacks a framed byte stream into 14-bit program words,
// writes them to program memory and releases the cpu once the checksum verifies.
module prog_loader #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned WORD_W = 14,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] W_HI   = 3'd3;
    localparam logic [2:0] W_LO   = 3'd4;
    localparam logic [2:0] CHK    = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [5:0]        hi_q, hi_d;
    logic [7:0]        sum_q, sum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic        accept;
    logic [7:0]  sum_next;
    logic [15:0] len_next;
    logic        last_word;

    assign rx_ready = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == W_HI) ||
                      (state_q == W_LO)   || (state_q == CHK);
    assign accept   = rx_valid && rx_ready;
    assign sum_next = sum_q + rx_data;
    assign len_next = {len_q[15:8], rx_data};
    // word_count counts words already accepted, so +1 gives the number of the word now arriving
    assign last_word = ((32'(word_count_q) + 32'd1) == 32'(len_q));

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        sum_d        = sum_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = LEN_HI;
                    word_count_d = '0;
                    sum_d        = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    sum_d   = sum_next;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = len_next;
                    sum_d = sum_next;
                    if ((len_next == 16'd0) || (32'(len_next) > DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = W_HI;
                    end
                end
            end
            W_HI: begin
                if (accept) begin
                    sum_d = sum_next;
                    if (rx_data[7:6] != 2'b00) begin
                        state_d = ERR;
                    end else begin
                        hi_d    = rx_data[5:0];
                        state_d = W_LO;
                    end
                end
            end
            W_LO: begin
                if (accept) begin
                    sum_d        = sum_next;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[ADDR_W-1:0];
                    mem_wdata_d  = {hi_q, rx_data};
                    word_count_d = word_count_q + 1'b1;
                    state_d      = last_word ? CHK : W_HI;
                end
            end
            CHK: begin
                if (accept) begin
                    sum_d   = sum_next;
                    state_d = (sum_next == 8'h00) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            hi_q         <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            sum_q        <= sum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign cpu_hold   = (state_q != DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: hand-built frame table, corner sequences
// and random frames scored against a frame-level reference model.
module tb_prog_loader;

    localparam int ADDR_W = 11;
    localparam int WORD_W = 14;
    localparam int DEPTH  = 2048;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0] b [10];
        int         nb;
        bit         exp_done;
        bit         exp_err;
        int         exp_wc;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [24:0] obs[$];
    logic [24:0] exp_w[$];

    prog_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) obs.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: walks the byte list by the frame rules, returns bytes consumed,
    // the expected write list (into exp_w) and whether the load ends verified.
    task automatic model(input bq_t f, output int used, output bit ok);
        int n;
        logic [7:0] s;
        logic [7:0] hi, lo;
        logic [10:0] a;
        exp_w.delete();
        ok   = 1'b0;
        n    = (int'(f[0]) << 8) | int'(f[1]);
        s    = f[0] + f[1];
        used = 2;
        if (n == 0 || n > DEPTH) return;
        for (int i = 0; i < n; i++) begin
            hi = f[2 + 2*i];
            used++;
            s = s + hi;
            if (hi[7:6] != 2'b00) return;
            lo = f[3 + 2*i];
            used++;
            s = s + lo;
            a = i[10:0];
            exp_w.push_back({a, hi[5:0], lo});
        end
        s = s + f[2 + 2*n];
        used++;
        ok = (s == 8'h00);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        bit got;
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                got = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        rx_data  = $urandom;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted, required rx_ready", b);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, ".nwrites"}, obs.size(), exp_w.size());
        for (int i = 0; i < obs.size() && i < exp_w.size(); i++)
            check($sformatf("%s.write%0d", tag, i), obs[i], exp_w[i]);
    endtask

    task automatic run_load(input bq_t f, input int gap_max, input bit mid_start,
                            input bit exp_done, input bit exp_err, input int exp_wc,
                            input string tag);
        int used;
        bit ok;
        model(f, used, ok);
        obs.delete();
        pulse_start();
        for (int i = 0; i < used; i++) begin
            if (mid_start && i == 1) pulse_start();
            send_byte(f[i], gap_max);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, ".done"},       done,       exp_done);
        check({tag, ".error"},      error,      exp_err);
        check({tag, ".cpu_hold"},   cpu_hold,   !exp_done);
        check({tag, ".rx_ready"},   rx_ready,   1'b0);
        check({tag, ".word_count"}, word_count, exp_wc);
        check_writes(tag);
    endtask

    vec_t vecs[6];

    initial begin
        bq_t f;
        int used;
        bit ok;
        logic [7:0] s;
        logic [13:0] w;

        vecs[0] = '{b: '{8'h00, 8'h02, 8'h28, 8'h05, 8'h07, 8'h81, 8'h49, 8'h00, 8'h00, 8'h00},
                    nb: 7, exp_done: 1, exp_err: 0, exp_wc: 2};
        vecs[1] = '{b: '{8'h00, 8'h02, 8'h28, 8'h05, 8'h07, 8'h81, 8'h48, 8'h00, 8'h00, 8'h00},
                    nb: 7, exp_done: 0, exp_err: 1, exp_wc: 2};
        vecs[2] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 2, exp_done: 0, exp_err: 1, exp_wc: 0};
        vecs[3] = '{b: '{8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 2, exp_done: 0, exp_err: 1, exp_wc: 0};
        vecs[4] = '{b: '{8'h00, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 3, exp_done: 0, exp_err: 1, exp_wc: 0};
        vecs[5] = '{b: '{8'h00, 8'h01, 8'h3F, 8'hFF, 8'hC1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 5, exp_done: 1, exp_err: 0, exp_wc: 1};

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.cpu_hold",   cpu_hold,   1'b1);
        check("reset.rx_ready",   rx_ready,   1'b0);
        check("reset.done",       done,       1'b0);
        check("reset.error",      error,      1'b0);
        check("reset.mem_we",     mem_we,     1'b0);
        check("reset.word_count", word_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            f.delete();
            for (int k = 0; k < vecs[v].nb; k++) f.push_back(vecs[v].b[k]);
            run_load(f, 0, 1'b0, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wc,
                     $sformatf("vec%0d", v));
            if (v == 0) begin
                check("vec0.hold_addr",  mem_addr,  1);
                check("vec0.hold_wdata", mem_wdata, 14'h0781);
                check("vec0.we_low",     mem_we,    1'b0);
            end
        end

        // reset after three bytes with gaps, then a full load with a stray start inside it
        f.delete();
        for (int k = 0; k < 7; k++) f.push_back(vecs[0].b[k]);
        pulse_start();
        for (int k = 0; k < 3; k++) send_byte(f[k], 3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset.rx_ready",   rx_ready,   1'b0);
        check("midreset.cpu_hold",   cpu_hold,   1'b1);
        check("midreset.done",       done,       1'b0);
        check("midreset.mem_we",     mem_we,     1'b0);
        check("midreset.word_count", word_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_load(f, 3, 1'b1, 1'b1, 1'b0, 2, "afterreset");

        // largest accepted program
        f.delete();
        f.push_back(8'h08);
        f.push_back(8'h00);
        s = 8'h08;
        for (int i = 0; i < DEPTH; i++) begin
            w = 14'(i * 7 + 3);
            f.push_back({2'b00, w[13:8]});
            f.push_back(w[7:0]);
            s = s + {2'b00, w[13:8]} + w[7:0];
        end
        f.push_back(8'h00 - s);
        run_load(f, 0, 1'b0, 1'b1, 1'b0, DEPTH, "maxdepth");

        for (int r = 0; r < 20; r++) begin
            int n;
            f.delete();
            n = int'($urandom_range(6, 1));
            f.push_back(8'h00);
            f.push_back(8'(n));
            s = 8'(n);
            for (int i = 0; i < n; i++) begin
                logic [7:0] hi, lo;
                hi = {2'b00, 6'($urandom)};
                if ($urandom_range(9, 0) == 0) hi[7:6] = 2'($urandom_range(3, 1));
                lo = 8'($urandom);
                f.push_back(hi);
                f.push_back(lo);
                s = s + hi + lo;
            end
            if ($urandom_range(4, 0) == 0) f.push_back(8'h00 - s + 8'($urandom_range(255, 1)));
            else f.push_back(8'h00 - s);
            model(f, used, ok);
            run_load(f, 3, 1'b0, ok, !ok, exp_w.size(), $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
